// File: rtl/spi_cfg_sequencer.sv
// spi_cfg_sequencer: queues register-write commands and serialises each as a 16-bit mode-0 SPI frame.
// Build macro SPI_SEQ_INIT_EN: after reset, writes 0x00 to registers 0..4 before accepting commands.
module spi_cfg_sequencer #(
    parameter int CLK_DIV    = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int TRAIL_CLKS = 1,
    parameter int CS_GAP     = 8,
    parameter int MAX_ADDR   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [6:0] cmd_addr,
    input  logic [7:0] cmd_data,
    output logic       SCLK,
    output logic       nCS,
    output logic       COPI,
    output logic       busy,
    output logic       frame_done,
    output logic       err_addr
);
    localparam int CNT_MAX = ((2 * CLK_DIV) > CS_GAP) ? (2 * CLK_DIV - 1) : (CS_GAP - 1);
    localparam int CW      = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
    localparam int PW      = $clog2(FIFO_DEPTH);
    localparam int QW      = PW + 1;
    localparam int TW      = (TRAIL_CLKS > 1) ? $clog2(TRAIL_CLKS) : 1;
    localparam logic [TW-1:0] TRAIL_LAST = (TRAIL_CLKS > 0) ? TW'(TRAIL_CLKS - 1) : '0;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        TRAIL = 3'd3,
        HOLD  = 3'd4,
        GAP   = 3'd5
    } state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg;
    logic [3:0]      bit_reg;
    logic [TW-1:0]   trail_reg;
    logic [15:0]     shift_reg;

    logic [14:0]     fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [QW-1:0]   count_reg, count_next;

    logic            sclk_reg, ncs_reg, copi_reg, busy_reg, frame_done_reg, err_addr_reg, cmd_ready_reg;
    logic            sclk_next, ncs_next, copi_next, busy_next, frame_done_next, err_addr_next, cmd_ready_next;

    logic            accept, legal, push, pop, start, load_init;
    logic            half_end, period_end, gap_end, last_bit, last_trail;
    logic            init_pending, init_pending_next;
    logic [6:0]      init_addr;

    assign accept     = cmd_valid && cmd_ready_reg;
    assign legal      = cmd_addr <= 7'(MAX_ADDR);
    assign push       = accept && legal;
    assign pop        = (state_reg == IDLE) && !init_pending && (count_reg != '0);
    assign start      = pop || load_init;

    assign half_end   = cnt_reg == CW'(CLK_DIV - 1);
    assign period_end = cnt_reg == CW'(2 * CLK_DIV - 1);
    assign gap_end    = cnt_reg == CW'(CS_GAP - 1);
    assign last_bit   = bit_reg == 4'd15;
    assign last_trail = trail_reg == TRAIL_LAST;

`ifdef SPI_SEQ_INIT_EN
    // Init frames bypass the FIFO; commands stay blocked until the fifth frame's gap has elapsed.
    logic [2:0] init_idx_reg;
    logic       init_pending_reg;

    assign init_pending      = init_pending_reg;
    assign init_pending_next = init_pending_reg &&
                               !((state_reg == GAP) && gap_end && (init_idx_reg == 3'd5));
    assign load_init         = (state_reg == IDLE) && init_pending_reg && (init_idx_reg != 3'd5);
    assign init_addr         = {4'd0, init_idx_reg};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_idx_reg     <= '0;
            init_pending_reg <= 1'b1;
        end else begin
            if (load_init)
                init_idx_reg <= init_idx_reg + 3'd1;
            init_pending_reg <= init_pending_next;
        end
    end
`else
    assign init_pending      = 1'b0;
    assign init_pending_next = 1'b0;
    assign load_init         = 1'b0;
    assign init_addr         = '0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = SETUP;
            SETUP:   if (half_end) state_next = SHIFT;
            SHIFT:   if (period_end && last_bit) state_next = (TRAIL_CLKS > 0) ? TRAIL : HOLD;
            TRAIL:   if (period_end && last_trail) state_next = HOLD;
            HOLD:    if (half_end) state_next = GAP;
            GAP:     if (gap_end) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Phase counter restarts on every state change and at the end of each SCLK period
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg   <= '0;
            bit_reg   <= '0;
            trail_reg <= '0;
            shift_reg <= '0;
        end else begin
            if ((state_next != state_reg) || (state_reg == IDLE) ||
                (((state_reg == SHIFT) || (state_reg == TRAIL)) && period_end))
                cnt_reg <= '0;
            else
                cnt_reg <= cnt_reg + 1'b1;

            if (state_reg == SETUP)
                bit_reg <= '0;
            else if ((state_reg == SHIFT) && period_end)
                bit_reg <= bit_reg + 4'd1;

            if (state_reg != TRAIL)
                trail_reg <= '0;
            else if (period_end)
                trail_reg <= trail_reg + 1'b1;

            // Shifting on the last high cycle makes COPI change together with the SCLK fall
            if (start)
                shift_reg <= load_init ? {1'b1, init_addr, 8'h00} : {1'b1, fifo_mem[rd_ptr_reg]};
            else if ((state_reg == SHIFT) && half_end)
                shift_reg <= {shift_reg[14:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr_reg] <= {cmd_addr, cmd_data};
    end

    always_comb begin
        count_next = count_reg;
        if (push && !pop)
            count_next = count_reg + 1'b1;
        else if (!push && pop)
            count_next = count_reg - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_next;
        end
    end

    // Output decode; every pin is registered, so the pins trail the state by one cycle
    always_comb begin
        ncs_next        = !((state_reg == SETUP) || (state_reg == SHIFT) ||
                            (state_reg == TRAIL) || (state_reg == HOLD));
        sclk_next       = ((state_reg == SHIFT) || (state_reg == TRAIL)) && (cnt_reg < CW'(CLK_DIV));
        copi_next       = ((state_reg == SETUP) || (state_reg == SHIFT)) && shift_reg[15];
        frame_done_next = (state_reg == GAP) && (cnt_reg == '0);
        busy_next       = (state_reg != IDLE) || (count_reg != '0) || init_pending;
        err_addr_next   = accept && !legal;
        cmd_ready_next  = (count_next != QW'(FIFO_DEPTH)) && !init_pending_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_reg       <= 1'b0;
            ncs_reg        <= 1'b1;
            copi_reg       <= 1'b0;
            busy_reg       <= 1'b0;
            frame_done_reg <= 1'b0;
            err_addr_reg   <= 1'b0;
            cmd_ready_reg  <= 1'b0;
        end else begin
            sclk_reg       <= sclk_next;
            ncs_reg        <= ncs_next;
            copi_reg       <= copi_next;
            busy_reg       <= busy_next;
            frame_done_reg <= frame_done_next;
            err_addr_reg   <= err_addr_next;
            cmd_ready_reg  <= cmd_ready_next;
        end
    end

    assign SCLK       = sclk_reg;
    assign nCS        = ncs_reg;
    assign COPI       = copi_reg;
    assign busy       = busy_reg;
    assign frame_done = frame_done_reg;
    assign err_addr   = err_addr_reg;
    assign cmd_ready  = cmd_ready_reg;

endmodule
